mag_compare_seq: RTL and testbench

MAG_COMPARE_SEQ -- requirements
Module: mag_compare_seq

---
 rtl/mag_compare_seq.sv | 140 ++++++++++++++
 tb/tb_mag_compare_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_compare_seq.sv
`default_nettype none
// ============================================================================
// Module   : mag_compare_seq
// Brief    : Digit-serial magnitude comparator, MSB digit first, with a
//            valid/ready handshake on both sides. Optional signed compare is
//            enabled by defining CMP_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mag_compare_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = ~({WIDTH{1'b1}} >> 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic             w_sm;
    logic [WIDTH-1:0] w_flip;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;

`ifdef CMP_SIGNED_EN
    assign w_sm = signed_mode;
`else
    assign w_sm = 1'b0;
`endif

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign w_flip = w_sm ? MSB_MASK : '0;
    assign w_da   = a_q[WIDTH-1 -: DIGIT];
    assign w_db   = b_q[WIDTH-1 -: DIGIT];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A ^ w_flip;
                    b_d     = B ^ w_flip;
                    cnt_d   = '0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (w_da != w_db) begin
                    gt_d    = (w_da > w_db);
                    lt_d    = (w_da < w_db);
                    state_d = S_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Flags drop with out_valid so they are never seen outside DONE.
                if (out_ready) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign A_gt_B    = gt_q;
    assign A_eq_B    = eq_q;
    assign A_lt_B    = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_compare_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_compare_seq
// Brief    : Self-checking bench for mag_compare_seq (8/2 and 2/1 configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mag_compare_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] A, B;
    logic       sm_r;
    logic       gt, eq, lt;

    logic       iv2, ir2, ov2, or2;
    logic [1:0] a2, b2;
    logic       g2, e2, l2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mag_compare_seq #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm_r),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A_gt_B     (gt),
        .A_eq_B     (eq),
        .A_lt_B     (lt)
    );

`ifdef CMP_SIGNED_EN
    logic sm2 = 1'b0;
`endif

    mag_compare_seq #(.WIDTH(2), .DIGIT(1)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv2),
        .in_ready   (ir2),
        .A          (a2),
        .B          (b2),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm2),
`endif
        .out_valid  (ov2),
        .out_ready  (or2),
        .A_gt_B     (g2),
        .A_eq_B     (e2),
        .A_lt_B     (l2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic       gt;
        logic       eq;
        logic       lt;
        int         k;
        int         hold;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic g, input logic e, input logic l, input int k, input int hold);
        vec_t v;
        v.a = a; v.b = b; v.sm = sm; v.gt = g; v.eq = e; v.lt = l; v.k = k; v.hold = hold;
        tbl.push_back(v);
    endtask

    // Reference: integer ordering, latency from offset-binary base-4 digits.
    function automatic void ref_model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                      output logic g, output logic e, output logic l, output int k);
        int ia, ib, ua, ub, p;
        if (sm) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        g  = (ia > ib);
        e  = (ia == ib);
        l  = (ia < ib);
        ua = ia + (sm ? 128 : 0);
        ub = ib + (sm ? 128 : 0);
        k  = 4;
        p  = 64;
        for (int i = 0; i < 4; i++) begin
            if (((ua / p) % 4) != ((ub / p) % 4)) begin
                k = i + 1;
                break;
            end
            p = p / 4;
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm,
                           input logic eg, input logic ee, input logic el, input int ek, input int hold);
        int lat;
        check({tag, " in_ready idle"}, in_ready, 1);
        A = a; B = b; sm_r = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); sm_r = 1'($urandom);
        check({tag, " in_ready busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if ({gt, eq, lt} !== 3'b000) check({tag, " flags before valid"}, {gt, eq, lt}, 0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, ek);
        check({tag, " flags"}, {gt, eq, lt}, {eg, ee, el});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom);
            @(posedge clk); #1;
            check({tag, " hold valid"}, out_valid, 1);
            check({tag, " hold in_ready"}, in_ready, 0);
            check({tag, " hold flags"}, {gt, eq, lt}, {eg, ee, el});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post valid"}, out_valid, 0);
        check({tag, " post flags"}, {gt, eq, lt}, 0);
        check({tag, " post in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic eg, ee, el;
        int   ek, lat, ea, eb;
        logic [7:0] ra, rb;
        logic rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; sm_r = 1'b0;
        iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset flags", {gt, eq, lt}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        add(8'hC3, 8'h43, 1'b0, 1, 0, 0, 1, 5);
        add(8'h5A, 8'h5A, 1'b0, 0, 1, 0, 4, 0);
        add(8'h12, 8'h13, 1'b0, 0, 0, 1, 4, 0);
        add(8'h13, 8'h12, 1'b0, 1, 0, 0, 4, 2);
        add(8'h00, 8'h00, 1'b0, 0, 1, 0, 4, 0);
        add(8'hFF, 8'h00, 1'b0, 1, 0, 0, 1, 0);
        add(8'h00, 8'hFF, 1'b0, 0, 0, 1, 1, 0);
        add(8'h04, 8'h08, 1'b0, 0, 0, 1, 3, 0);
        add(8'h31, 8'h21, 1'b0, 1, 0, 0, 2, 1);
`ifdef CMP_SIGNED_EN
        add(8'h80, 8'h7F, 1'b1, 0, 0, 1, 1, 0);
        add(8'h80, 8'h7F, 1'b0, 1, 0, 0, 1, 0);
        add(8'hFF, 8'h01, 1'b1, 0, 0, 1, 1, 0);
`endif
        foreach (tbl[i]) begin
            run_cmp($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm,
                    tbl[i].gt, tbl[i].eq, tbl[i].lt, tbl[i].k, tbl[i].hold);
        end

        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom);
            rb = (r % 4 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
`ifdef CMP_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            ref_model(ra, rb, rs, eg, ee, el, ek);
            run_cmp($sformatf("rnd%0d", r), ra, rb, rs, eg, ee, el, ek, r % 3);
        end

        // Reset in the middle of a compare must drop the pending result.
        A = 8'h5A; B = 8'h5A; sm_r = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst async out_valid", out_valid, 0);
        check("rst async in_ready", in_ready, 1);
        check("rst async flags", {gt, eq, lt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("after rst out_valid", out_valid, 0);
            check("after rst in_ready", in_ready, 1);
            check("after rst flags", {gt, eq, lt}, 0);
        end

        // Exhaustive 2-bit compare, one bit per cycle.
        for (int p = 0; p < 16; p++) begin
            ea = p / 4;
            eb = p % 4;
            a2 = 2'(ea); b2 = 2'(eb); iv2 = 1'b1;
            @(posedge clk); #1;
            iv2 = 1'b0;
            lat = 0;
            while (!ov2 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("w2 pair%0d latency", p), lat, ((ea / 2) != (eb / 2)) ? 1 : 2);
            check($sformatf("w2 pair%0d flags", p), {g2, e2, l2}, {ea > eb, ea == eb, ea < eb});
            or2 = 1'b1;
            @(posedge clk); #1;
            or2 = 1'b0;
            check($sformatf("w2 pair%0d idle", p), {ir2, ov2}, 2'b10);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
